router_fsm: RTL and testbench

Control FSM for the 1-to-3 packet router. It sits between the router's input register block and its three output FIFOs. It decodes the 2-bit destination address from the packet header and sequences header, payload and parity loading. It also handles FIFO-full back-pressure and waiting for a busy destination, and drives the load/enable strobes and the `busy` flag back to the source.

---
 rtl/router_fsm_if.sv | 41 ++++
 rtl/router_fsm.sv | 127 ++++++++++++
 tb/tb_router_fsm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// Handshake/strobe bundle between the router's register block, FIFOs and the control FSM.
// The FSM takes the slave view; the surrounding datapath (or a bench) takes the master view.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       write_enb_reg;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       lfd_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       busy;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output write_enb_reg, detect_add, ld_state, laf_state,
        output lfd_state, full_state, rst_int_reg, busy
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  write_enb_reg, detect_add, ld_state, laf_state,
        input  lfd_state, full_state, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1-to-3 packet router: address decode, load sequencing, back-pressure.
// Define ROUTER_FSM_SOFT_RESET_EN to let a timed-out destination FIFO abort the packet.
module router_fsm (
    input  logic        clock,
    input  logic        resetn,
    router_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        StDecodeAddress,
        StLoadFirstData,
        StLoadData,
        StLoadParity,
        StCheckParityError,
        StFifoFullState,
        StLoadAfterFull,
        StWaitTillEmpty
    } state_e;

    state_e     r_state;
    state_e     w_next_state;
    logic [1:0] r_addr;
    logic [1:0] w_next_addr;
    logic       w_hdr_empty;
    logic       w_addr_empty;
    logic       w_soft_reset;

    // Emptiness of the FIFO named by the incoming header.
    always_comb begin
        case (bus.data_in)
            2'd0:    w_hdr_empty = bus.fifo_empty_0;
            2'd1:    w_hdr_empty = bus.fifo_empty_1;
            2'd2:    w_hdr_empty = bus.fifo_empty_2;
            default: w_hdr_empty = 1'b0;
        endcase
    end

    // Emptiness of the FIFO named by the latched address.
    always_comb begin
        case (r_addr)
            2'd0:    w_addr_empty = bus.fifo_empty_0;
            2'd1:    w_addr_empty = bus.fifo_empty_1;
            2'd2:    w_addr_empty = bus.fifo_empty_2;
            default: w_addr_empty = 1'b0;
        endcase
    end

`ifdef ROUTER_FSM_SOFT_RESET_EN
    logic w_sel_soft_reset;

    always_comb begin
        case (r_addr)
            2'd0:    w_sel_soft_reset = bus.soft_reset_0;
            2'd1:    w_sel_soft_reset = bus.soft_reset_1;
            2'd2:    w_sel_soft_reset = bus.soft_reset_2;
            default: w_sel_soft_reset = 1'b0;
        endcase
    end

    assign w_soft_reset = w_sel_soft_reset && (r_state != StDecodeAddress);
`else
    logic w_unused_soft_reset;

    assign w_unused_soft_reset = bus.soft_reset_0 ^ bus.soft_reset_1 ^ bus.soft_reset_2;
    assign w_soft_reset        = 1'b0;
`endif

    assign w_next_addr = ((r_state == StDecodeAddress) && bus.pkt_valid) ? bus.data_in : r_addr;

    always_comb begin
        w_next_state = r_state;
        if (w_soft_reset) begin
            w_next_state = StDecodeAddress;
        end else begin
            case (r_state)
                StDecodeAddress: begin
                    if (bus.pkt_valid && (bus.data_in != 2'd3)) begin
                        w_next_state = w_hdr_empty ? StLoadFirstData : StWaitTillEmpty;
                    end
                end
                StLoadFirstData: w_next_state = StLoadData;
                StLoadData: begin
                    if (bus.fifo_full)       w_next_state = StFifoFullState;
                    else if (!bus.pkt_valid) w_next_state = StLoadParity;
                end
                StFifoFullState: begin
                    if (!bus.fifo_full) w_next_state = StLoadAfterFull;
                end
                StLoadAfterFull: begin
                    if (bus.parity_done)        w_next_state = StDecodeAddress;
                    else if (bus.low_pkt_valid) w_next_state = StLoadParity;
                    else                        w_next_state = StLoadData;
                end
                StLoadParity: w_next_state = StCheckParityError;
                StCheckParityError: begin
                    w_next_state = bus.fifo_full ? StFifoFullState : StDecodeAddress;
                end
                StWaitTillEmpty: begin
                    if (w_addr_empty) w_next_state = StLoadFirstData;
                end
                default: w_next_state = StDecodeAddress;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state <= StDecodeAddress;
            r_addr  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
        end
    end

    // Moore outputs: decoded from the registered state only.
    always_comb begin
        bus.detect_add    = (r_state == StDecodeAddress);
        bus.lfd_state     = (r_state == StLoadFirstData);
        bus.ld_state      = (r_state == StLoadData);
        bus.laf_state     = (r_state == StLoadAfterFull);
        bus.full_state    = (r_state == StFifoFullState);
        bus.rst_int_reg   = (r_state == StCheckParityError);
        bus.write_enb_reg = (r_state == StLoadData) || (r_state == StLoadParity)
                          || (r_state == StLoadAfterFull);
        bus.busy          = (r_state != StDecodeAddress) && (r_state != StLoadData);
    end
endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed test-plan sequences plus randomized traffic,
// all compared every cycle against a behavioural model of the packet-routing rules.
module tb_router_fsm;
    localparam int DA  = 0;
    localparam int LFD = 1;
    localparam int LD  = 2;
    localparam int LP  = 3;
    localparam int CPE = 4;
    localparam int FFS = 5;
    localparam int LAF = 6;
    localparam int WTE = 7;

`ifdef ROUTER_FSM_SOFT_RESET_EN
    localparam bit SR_EN = 1'b1;
`else
    localparam bit SR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 1'b0;

    router_fsm_if bus ();

    router_fsm u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Output vector: {detect, lfd, ld, laf, full, rst_int, write_enb, busy}
    logic [7:0] dut_vec;
    assign dut_vec = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                      bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};

    function automatic logic [7:0] expect_out(int s);
        logic [7:0] v;
        v[7] = (s == DA);
        v[6] = (s == LFD);
        v[5] = (s == LD);
        v[4] = (s == LAF);
        v[3] = (s == FFS);
        v[2] = (s == CPE);
        v[1] = (s == LD) || (s == LP) || (s == LAF);
        v[0] = !((s == DA) || (s == LD));
        return v;
    endfunction

    function automatic int model_next(int s, logic [1:0] a, logic pv, logic [1:0] din,
                                      logic ff, logic [2:0] emp, logic [2:0] sr,
                                      logic pd, logic lpv);
        if (SR_EN && (s != DA) && (a != 2'd3) && sr[a]) return DA;
        if (s == DA) begin
            if (pv && (din != 2'd3)) return emp[din] ? LFD : WTE;
            return DA;
        end
        if (s == LFD) return LD;
        if (s == LD) return ff ? FFS : (!pv ? LP : LD);
        if (s == FFS) return ff ? FFS : LAF;
        if (s == LAF) return pd ? DA : (lpv ? LP : LD);
        if (s == LP) return CPE;
        if (s == CPE) return ff ? FFS : DA;
        return ((a != 2'd3) && emp[a]) ? LFD : WTE;
    endfunction

    int         m_state = DA;
    logic [1:0] m_addr  = 2'd0;

    always @(posedge clock) begin
        if (resetn) begin
            m_state <= DA;
            m_addr  <= 2'd0;
        end else begin
            if ((m_state == DA) && bus.pkt_valid) m_addr <= bus.data_in;
            m_state <= model_next(m_state, m_addr, bus.pkt_valid, bus.data_in, bus.fifo_full,
                                  {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0},
                                  {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0},
                                  bus.parity_done, bus.low_pkt_valid);
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            checks++;
            if (dut_vec !== expect_out(m_state)) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t got=%b required=%b model_state=%0d",
                         $time, dut_vec, expect_out(m_state), m_state);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Literal expectation pinning both the DUT and the model.
    task automatic chk(string name, logic [7:0] exp);
        checks++;
        if (dut_vec !== exp) begin
            failures++;
            $display("FAIL %s dut got=%b required=%b", name, dut_vec, exp);
        end
        checks++;
        if (expect_out(m_state) !== exp) begin
            failures++;
            $display("FAIL %s model got=%b required=%b", name, expect_out(m_state), exp);
        end
    endtask

    task automatic set_sr(logic s0, logic s1, logic s2);
        bus.soft_reset_0 = s0;
        bus.soft_reset_1 = s1;
        bus.soft_reset_2 = s2;
    endtask

    initial begin
        resetn            = 1'b1;
        set_sr(1'b1, 1'b1, 1'b1);
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        step();
        cmp_en = 1'b1;
        chk("reset", 8'h80);
        resetn = 1'b0;
        step(); chk("idle_sr_high", 8'h80);
        set_sr(1'b0, 1'b0, 1'b0);
        step(); chk("idle", 8'h80);

        // Normal packet to FIFO 2
        bus.data_in = 2'd2; bus.pkt_valid = 1'b1;
        step(); chk("norm_lfd", 8'h41);
        step(); chk("norm_ld", 8'h22);
        step(); chk("norm_ld_hold", 8'h22);
        bus.pkt_valid = 1'b0;
        step(); chk("norm_lp", 8'h03);
        step(); chk("norm_cpe", 8'h05);
        step(); chk("norm_da", 8'h80);

        // Invalid address is ignored
        bus.data_in = 2'd3; bus.pkt_valid = 1'b1;
        step(); chk("addr3_stay", 8'h80);

        // Full back-pressure, then low_pkt_valid path
        bus.data_in = 2'd0;
        step(); chk("full_lfd", 8'h41);
        step(); chk("full_ld", 8'h22);
        bus.fifo_full = 1'b1;
        step(); chk("full_ffs", 8'h09);
        step(); chk("full_ffs_hold", 8'h09);
        bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1; bus.pkt_valid = 1'b0;
        step(); chk("full_laf", 8'h13);
        step(); chk("full_lp", 8'h03);
        bus.low_pkt_valid = 1'b0;
        step(); chk("full_cpe", 8'h05);
        step(); chk("full_da", 8'h80);

        // LAF with parity_done returns to DA
        bus.data_in = 2'd1; bus.pkt_valid = 1'b1;
        step(); step(); chk("laf1_ld", 8'h22);
        bus.fifo_full = 1'b1;
        step(); chk("laf1_ffs", 8'h09);
        bus.fifo_full = 1'b0; bus.parity_done = 1'b1; bus.pkt_valid = 1'b0;
        step(); chk("laf1_laf", 8'h13);
        step(); chk("laf1_da", 8'h80);
        bus.parity_done = 1'b0;

        // LAF falls back to LD
        bus.pkt_valid = 1'b1;
        step(); step();
        bus.fifo_full = 1'b1;
        step();
        bus.fifo_full = 1'b0;
        step(); chk("laf2_laf", 8'h13);
        step(); chk("laf2_ld", 8'h22);
        bus.pkt_valid = 1'b0;
        step(); step(); step(); chk("laf2_da", 8'h80);

        // Busy destination
        bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b0; bus.pkt_valid = 1'b1;
        step(); chk("wte_enter", 8'h01);
        bus.pkt_valid = 1'b0;
        step(); chk("wte_hold", 8'h01);
        bus.fifo_empty_2 = 1'b1;
        step(); chk("wte_lfd", 8'h41);
        step(); step(); step(); step(); chk("wte_done_da", 8'h80);

        // Soft reset only for the selected FIFO
        bus.fifo_empty_2 = 1'b0; bus.pkt_valid = 1'b1;
        step(); chk("sr_wte", 8'h01);
        bus.pkt_valid = 1'b0;
        set_sr(1'b0, 1'b1, 1'b0);
        step(); chk("sr_other_ignored", 8'h01);
        set_sr(1'b0, 1'b0, 1'b1);
        step(); chk("sr_selected", SR_EN ? 8'h80 : 8'h01);
        set_sr(1'b0, 1'b0, 1'b0);
        bus.fifo_empty_2 = 1'b1;

        // Reset mid-packet
        resetn = 1'b1;
        step();
        resetn = 1'b0; bus.data_in = 2'd1; bus.pkt_valid = 1'b1;
        step(); step(); chk("mid_ld", 8'h22);
        resetn = 1'b1;
        step(); chk("mid_reset", 8'h80);
        resetn = 1'b0; bus.pkt_valid = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            resetn            = ($urandom_range(0, 99) < 2);
            bus.pkt_valid     = ($urandom_range(0, 99) < 75);
            bus.data_in       = 2'($urandom_range(0, 3));
            bus.fifo_full     = ($urandom_range(0, 99) < 25);
            bus.fifo_empty_0  = ($urandom_range(0, 99) < 70);
            bus.fifo_empty_1  = ($urandom_range(0, 99) < 70);
            bus.fifo_empty_2  = ($urandom_range(0, 99) < 70);
            bus.soft_reset_0  = ($urandom_range(0, 99) < 4);
            bus.soft_reset_1  = ($urandom_range(0, 99) < 4);
            bus.soft_reset_2  = ($urandom_range(0, 99) < 4);
            bus.parity_done   = ($urandom_range(0, 99) < 30);
            bus.low_pkt_valid = ($urandom_range(0, 99) < 30);
            step();
        end

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
